svc_rv_rvfi_tracer: RTL and testbench

Multi-lane RVFI retirement tracer for SoC benches and debug builds. It captures the last DEPTH retired instructions (pc, insn) into a ring buffer and counts cycles and retirements. It detects halt, trap and watchdog timeout, and exposes the history through a registered read port. Benches wait on its terminal state and dump the trace on failure, instead of polling rvfi_valid/rvfi_halt directly.

---
 rtl/svc_rv_rvfi_tracer.sv | 222 ++++++++++++++++++++++
 tb/tb_svc_rv_rvfi_tracer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_rvfi_tracer.sv
// Multi-lane RVFI retirement tracer: a ring buffer of the last DEPTH retirements, plus counters and halt/trap/timeout detection.
// Optional define SVC_RV_TRACER_ORDER_EN adds a sticky check that rvfi_order values arrive consecutively.
module svc_rv_rvfi_tracer #(
    parameter int XLEN    = 32,
    parameter int NRET    = 1,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [NRET*XLEN-1:0] rvfi_pc_rdata,
    input  logic [NRET*32-1:0]   rvfi_insn,
    input  logic [NRET-1:0]      rvfi_halt,
    input  logic [NRET-1:0]      rvfi_trap,
    input  logic [NRET*64-1:0]   rvfi_order,
    output logic [2:0]           state,
    output logic                 done,
    output logic [AW:0]          count,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic [CNT_W-1:0]     cycle_cnt,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_idx,
    output logic                 rd_valid,
    output logic                 rd_hit,
    output logic [XLEN-1:0]      rd_pc,
    output logic [31:0]          rd_insn,
    output logic                 order_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_HALT    = 3'd2,
        S_TRAP    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW:0]           count_q, count_d;
    logic [CNT_W-1:0]      retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0]      cycle_cnt_q, cycle_cnt_d;

    logic                  run_active;
    logic [NRET-1:0]       lane_acc;
    logic [AW-1:0]         lane_rank [NRET];
    logic [AW:0]           acc_n;
    logic                  term_trap, term_halt, lane_stop;
    logic                  timeout_hit;
    logic [AW+1:0]         count_sum;
    logic [CNT_W:0]        retire_sum;

    logic [XLEN-1:0]       pc_mem   [DEPTH];
    logic [31:0]           insn_mem [DEPTH];

    logic                  rd_valid_q, rd_hit_q;
    logic [XLEN-1:0]       rd_pc_q;
    logic [31:0]           rd_insn_q;
    logic [AW-1:0]         rd_ptr;
    logic                  rd_hit_c;

    // Retirements are only taken in RUN; a start in the same cycle discards them.
    assign run_active = (state_q == S_RUN) && !start;

    // Lane scan: compact accepted lanes into consecutive ranks and stop after the first terminal lane.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        lane_acc  = '0;
        acc_n     = '0;
        term_trap = 1'b0;
        term_halt = 1'b0;
        lane_stop = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            lane_rank[k] = acc_n[AW-1:0];
            if (run_active && !lane_stop && rvfi_valid[k]) begin
                lane_acc[k] = 1'b1;
                acc_n       = acc_n + (AW+1)'(1);
                if (rvfi_trap[k] || rvfi_halt[k]) begin
                    lane_stop = 1'b1;
                    term_trap = rvfi_trap[k];
                    term_halt = rvfi_halt[k];
                end
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && run_active && (cycle_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            if (term_trap)        state_d = S_TRAP;
            else if (term_halt)   state_d = S_HALT;
            else if (timeout_hit) state_d = S_TIMEOUT;
        end
    end

    always_comb begin
        done = (state_q == S_HALT) || (state_q == S_TRAP) || (state_q == S_TIMEOUT);
    end

    assign count_sum  = {1'b0, count_q} + {1'b0, acc_n};
    assign retire_sum = {1'b0, retire_cnt_q} + (CNT_W+1)'(acc_n);

    always_comb begin
        wptr_d       = wptr_q;
        count_d      = count_q;
        retire_cnt_d = retire_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        if (start) begin
            wptr_d       = '0;
            count_d      = '0;
            retire_cnt_d = '0;
            cycle_cnt_d  = '0;
        end else if (run_active) begin
            wptr_d       = wptr_q + acc_n[AW-1:0];
            count_d      = (count_sum > (AW+2)'(DEPTH)) ? (AW+1)'(DEPTH) : count_sum[AW:0];
            retire_cnt_d = retire_sum[CNT_W] ? '1 : retire_sum[CNT_W-1:0];
            cycle_cnt_d  = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wptr_q       <= '0;
            count_q      <= '0;
            retire_cnt_q <= '0;
            cycle_cnt_q  <= '0;
        end else begin
            wptr_q       <= wptr_d;
            count_q      <= count_d;
            retire_cnt_q <= retire_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    // NOTE: the ring is not reset; count gates every read, so stale contents are never exposed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NRET; k++) begin
            if (lane_acc[k]) begin
                pc_mem[wptr_q + lane_rank[k]]   <= rvfi_pc_rdata[k*XLEN +: XLEN];
                insn_mem[wptr_q + lane_rank[k]] <= rvfi_insn[k*32 +: 32];
            end
        end
    end

    assign rd_ptr   = wptr_q - AW'(1) - rd_idx;
    assign rd_hit_c = {1'b0, rd_idx} < count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_pc_q    <= '0;
            rd_insn_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_hit_q  <= rd_hit_c;
                rd_pc_q   <= rd_hit_c ? pc_mem[rd_ptr]   : '0;
                rd_insn_q <= rd_hit_c ? insn_mem[rd_ptr] : '0;
            end
        end
    end

`ifdef SVC_RV_TRACER_ORDER_EN
    logic [63:0] exp_order_q;
    logic        order_err_q;
    logic        order_bad;

    always_comb begin
        order_bad = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            if (lane_acc[k] && (rvfi_order[k*64 +: 64] != exp_order_q + 64'(lane_rank[k])))
                order_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_order_q <= '0;
            order_err_q <= 1'b0;
        end else if (start) begin
            exp_order_q <= '0;
            order_err_q <= 1'b0;
        end else if (run_active) begin
            exp_order_q <= exp_order_q + 64'(acc_n);
            if (order_bad) order_err_q <= 1'b1;
        end
    end

    assign order_err = order_err_q;
`else
    logic unused_order;
    assign unused_order = ^rvfi_order;
    assign order_err    = 1'b0;
`endif

    assign state      = state_q;
    assign count      = count_q;
    assign retire_cnt = retire_cnt_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign rd_valid   = rd_valid_q;
    assign rd_hit     = rd_hit_q;
    assign rd_pc      = rd_pc_q;
    assign rd_insn    = rd_insn_q;

endmodule

// File: tb/tb_svc_rv_rvfi_tracer.sv
// Directed bench for svc_rv_rvfi_tracer with two retire lanes, DEPTH 16 and a 50-cycle watchdog.
module tb_svc_rv_rvfi_tracer;

    localparam int XLEN    = 32;
    localparam int NRET    = 2;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 50;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [NRET-1:0]      rvfi_valid;
    logic [NRET*XLEN-1:0] rvfi_pc_rdata;
    logic [NRET*32-1:0]   rvfi_insn;
    logic [NRET-1:0]      rvfi_halt;
    logic [NRET-1:0]      rvfi_trap;
    logic [NRET*64-1:0]   rvfi_order;
    logic [2:0]           state;
    logic                 done;
    logic [4:0]           count;
    logic [CNT_W-1:0]     retire_cnt;
    logic [CNT_W-1:0]     cycle_cnt;
    logic                 rd_en;
    logic [3:0]           rd_idx;
    logic                 rd_valid;
    logic                 rd_hit;
    logic [XLEN-1:0]      rd_pc;
    logic [31:0]          rd_insn;
    logic                 order_err;

    int checks = 0;
    int errors = 0;
    logic oe_exp;

    svc_rv_rvfi_tracer #(
        .XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
        .rvfi_halt(rvfi_halt), .rvfi_trap(rvfi_trap), .rvfi_order(rvfi_order),
        .state(state), .done(done), .count(count),
        .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_hit(rd_hit),
        .rd_pc(rd_pc), .rd_insn(rd_insn), .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One retire cycle; inputs return to idle afterwards.
    task automatic lanes(input logic [1:0] v, input logic [1:0] h, input logic [1:0] t,
                         input logic [31:0] pc0, input logic [31:0] i0,
                         input logic [31:0] pc1, input logic [31:0] i1,
                         input logic [63:0] o0, input logic [63:0] o1);
        rvfi_valid    = v;
        rvfi_halt     = h;
        rvfi_trap     = t;
        rvfi_pc_rdata = {pc1, pc0};
        rvfi_insn     = {i1, i0};
        rvfi_order    = {o1, o0};
        tick();
        rvfi_valid    = '0;
        rvfi_halt     = '0;
        rvfi_trap     = '0;
        rvfi_pc_rdata = '0;
        rvfi_insn     = '0;
        rvfi_order    = '0;
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic hit,
                      input logic [31:0] pc, input logic [31:0] insn);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        rd_en  = 1'b0;
        check({tag, "_valid"}, 64'(rd_valid), 64'd1);
        check({tag, "_hit"},   64'(rd_hit),   64'(hit));
        check({tag, "_pc"},    64'(rd_pc),    64'(pc));
        check({tag, "_insn"},  64'(rd_insn),  64'(insn));
    endtask

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return 32'h0B00_0000 | pc;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; rd_en = 1'b0; rd_idx = '0;
        rvfi_valid = '0; rvfi_halt = '0; rvfi_trap = '0;
        rvfi_pc_rdata = '0; rvfi_insn = '0; rvfi_order = '0;
        #12;
        check("rst_state", 64'(state), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ret",   64'(retire_cnt), 64'd0);
        check("rst_cyc",   64'(cycle_cnt), 64'd0);
        check("rst_rdv",   64'(rd_valid), 64'd0);
        check("rst_oerr",  64'(order_err), 64'd0);
        rst_n = 1'b1;
        tick();
        rd("idle_rd", 4'd0, 1'b0, 32'h0, 32'h0);
        tick();
        check("rdv_pulse", 64'(rd_valid), 64'd0);
        lanes(2'b01, 2'b00, 2'b00, 32'h40, 32'h13, 32'h0, 32'h0, 64'd0, 64'd0);
        check("idle_ignore_cnt", 64'(count), 64'd0);
        check("idle_ignore_ret", 64'(retire_cnt), 64'd0);

        // Basic nop + ebreak.
        do_start();
        check("a_state_run", 64'(state), 64'd1);
        check("a_count0", 64'(count), 64'd0);
        lanes(2'b01, 2'b00, 2'b00, 32'h0, 32'h0000_0013, 32'h0, 32'h0, 64'd0, 64'd0);
        check("a_count1", 64'(count), 64'd1);
        lanes(2'b01, 2'b01, 2'b00, 32'h4, 32'h0010_0073, 32'h0, 32'h0, 64'd1, 64'd0);
        check("a_state_halt", 64'(state), 64'd2);
        check("a_done", 64'(done), 64'd1);
        check("a_ret", 64'(retire_cnt), 64'd2);
        check("a_count", 64'(count), 64'd2);
        check("a_cyc", 64'(cycle_cnt), 64'd2);
        rd("a_idx0", 4'd0, 1'b1, 32'h4, 32'h0010_0073);
        rd("a_idx1", 4'd1, 1'b1, 32'h0, 32'h0000_0013);
        rd("a_idx2", 4'd2, 1'b0, 32'h0, 32'h0);
        lanes(2'b01, 2'b00, 2'b00, 32'h8, 32'h13, 32'h0, 32'h0, 64'd2, 64'd0);
        check("a_sticky_state", 64'(state), 64'd2);
        check("a_frozen_cnt", 64'(count), 64'd2);
        check("a_frozen_cyc", 64'(cycle_cnt), 64'd2);
        check("a_oerr", 64'(order_err), 64'd0);

        // Wrap: 20 retirements into 16 entries.
        do_start();
        check("w_state", 64'(state), 64'd1);
        check("w_count0", 64'(count), 64'd0);
        check("w_ret0", 64'(retire_cnt), 64'd0);
        for (int i = 0; i < 20; i++)
            lanes(2'b01, 2'b00, 2'b00, 32'(4 * i), 32'h13 | 32'(i << 7), 32'h0, 32'h0, 64'(i), 64'd0);
        check("w_count", 64'(count), 64'd16);
        check("w_ret", 64'(retire_cnt), 64'd20);
        check("w_cyc", 64'(cycle_cnt), 64'd20);
        rd("w_idx0", 4'd0, 1'b1, 32'h4C, 32'h0000_0993);
        rd("w_idx15", 4'd15, 1'b1, 32'h10, 32'h0000_0213);
        check("w_cyc_after_rd", 64'(cycle_cnt), 64'd22);
        check("w_oerr", 64'(order_err), 64'd0);

        // Two lanes with compaction, then halt on lane 0 drops lane 1.
        do_start();
        lanes(2'b11, 2'b00, 2'b00, 32'h100, mk(32'h100), 32'h104, mk(32'h104), 64'd0, 64'd1);
        lanes(2'b11, 2'b00, 2'b00, 32'h108, mk(32'h108), 32'h10C, mk(32'h10C), 64'd2, 64'd3);
        lanes(2'b11, 2'b00, 2'b00, 32'h110, mk(32'h110), 32'h114, mk(32'h114), 64'd4, 64'd5);
        lanes(2'b10, 2'b00, 2'b00, 32'hDEAD_0000, 32'hDEAD_0000, 32'h118, mk(32'h118), 64'd77, 64'd6);
        check("m_ret", 64'(retire_cnt), 64'd7);
        check("m_count", 64'(count), 64'd7);
        rd("m_idx0", 4'd0, 1'b1, 32'h118, mk(32'h118));
        rd("m_idx1", 4'd1, 1'b1, 32'h114, mk(32'h114));
        rd("m_idx6", 4'd6, 1'b1, 32'h100, mk(32'h100));
        rd("m_idx7", 4'd7, 1'b0, 32'h0, 32'h0);
        lanes(2'b11, 2'b01, 2'b00, 32'h11C, mk(32'h11C), 32'h120, mk(32'h120), 64'd7, 64'd99);
        check("m_halt", 64'(state), 64'd2);
        check("m_ret_drop", 64'(retire_cnt), 64'd8);
        check("m_count_drop", 64'(count), 64'd8);
        rd("m_h_idx0", 4'd0, 1'b1, 32'h11C, mk(32'h11C));
        rd("m_h_idx1", 4'd1, 1'b1, 32'h118, mk(32'h118));
        check("m_oerr", 64'(order_err), 64'd0);

        // Trap and halt on the same lane: trap wins.
        do_start();
        lanes(2'b11, 2'b10, 2'b10, 32'h200, mk(32'h200), 32'h204, mk(32'h204), 64'd0, 64'd1);
        check("t_state", 64'(state), 64'd3);
        check("t_done", 64'(done), 64'd1);
        check("t_ret", 64'(retire_cnt), 64'd2);
        rd("t_idx0", 4'd0, 1'b1, 32'h204, mk(32'h204));

        // Watchdog expiry.
        do_start();
        repeat (49) tick();
        check("to_pre_state", 64'(state), 64'd1);
        check("to_pre_cyc", 64'(cycle_cnt), 64'd49);
        check("to_pre_done", 64'(done), 64'd0);
        tick();
        check("to_state", 64'(state), 64'd4);
        check("to_cyc", 64'(cycle_cnt), 64'd50);
        check("to_done", 64'(done), 64'd1);
        tick();
        check("to_frozen", 64'(cycle_cnt), 64'd50);
        check("to_sticky", 64'(state), 64'd4);

        // Halt in the watchdog's final cycle wins.
        do_start();
        repeat (49) tick();
        lanes(2'b01, 2'b01, 2'b00, 32'h300, mk(32'h300), 32'h0, 32'h0, 64'd0, 64'd0);
        check("toh_state", 64'(state), 64'd2);
        check("toh_cyc", 64'(cycle_cnt), 64'd50);
        check("toh_ret", 64'(retire_cnt), 64'd1);

        // Asynchronous reset in the middle of RUN.
        do_start();
        lanes(2'b01, 2'b00, 2'b00, 32'h400, mk(32'h400), 32'h0, 32'h0, 64'd0, 64'd0);
        rd_en = 1'b1; rd_idx = 4'd0;
        tick();
        rd_en = 1'b0;
        check("r_pre_rdv", 64'(rd_valid), 64'd1);
        check("r_pre_cnt", 64'(count), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("r_state", 64'(state), 64'd0);
        check("r_count", 64'(count), 64'd0);
        check("r_ret", 64'(retire_cnt), 64'd0);
        check("r_cyc", 64'(cycle_cnt), 64'd0);
        check("r_rdv", 64'(rd_valid), 64'd0);
        check("r_rdhit", 64'(rd_hit), 64'd0);
        check("r_rdpc", 64'(rd_pc), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("r_idle", 64'(state), 64'd0);
        rd("r_rd", 4'd0, 1'b0, 32'h0, 32'h0);

        // Order sequence 0,1,3.
`ifdef SVC_RV_TRACER_ORDER_EN
        oe_exp = 1'b1;
`else
        oe_exp = 1'b0;
`endif
        do_start();
        lanes(2'b01, 2'b00, 2'b00, 32'h500, mk(32'h500), 32'h0, 32'h0, 64'd0, 64'd0);
        lanes(2'b01, 2'b00, 2'b00, 32'h504, mk(32'h504), 32'h0, 32'h0, 64'd1, 64'd0);
        check("o_ok", 64'(order_err), 64'd0);
        lanes(2'b01, 2'b00, 2'b00, 32'h508, mk(32'h508), 32'h0, 32'h0, 64'd3, 64'd0);
        check("o_err", 64'(order_err), 64'(oe_exp));
        lanes(2'b01, 2'b00, 2'b00, 32'h50C, mk(32'h50C), 32'h0, 32'h0, 64'd3, 64'd0);
        check("o_sticky", 64'(order_err), 64'(oe_exp));
        do_start();
        check("o_clear", 64'(order_err), 64'd0);
        check("o_start_cnt", 64'(count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
